// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store front-end: opcode values, FSM states
// and the opcode legality check used by the access unit.
package mem_access_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WRITE,
    S_DONE
  } state_t;

  // Unsigned variants only make sense for loads, so a store with op[2] set is illegal.
  function automatic logic is_legal_op(input logic [2:0] op, input logic wr);
    logic known;
    known = (op == OP_B) || (op == OP_H) || (op == OP_W) ||
            (op == OP_BU) || (op == OP_HU);
    return known && !(wr && op[2]);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: extracts and extends load lanes from a RAM word
// and builds the merged word for byte/half stores (little-endian lanes).
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] ram_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_val,
  output logic [31:0] merge_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = ram_word[{lane, 3'b000} +: 8];
    half_sel   = lane[1] ? ram_word[31:16] : ram_word[15:0];
    load_val   = ram_word;
    merge_word = store_data;

    case (op)
      OP_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
      OP_BU:   load_val = {24'h000000, byte_sel};
      OP_H:    load_val = {{16{half_sel[15]}}, half_sel};
      OP_HU:   load_val = {16'h0000, half_sel};
      default: load_val = ram_word;
    endcase

    // Only the size bits matter here; legality has already been checked upstream.
    case (op[1:0])
      2'b00: begin
        merge_word = ram_word;
        merge_word[{lane, 3'b000} +: 8] = store_data[7:0];
      end
      2'b01:   merge_word = lane[1] ? {store_data[15:0], ram_word[15:0]}
                                    : {ram_word[31:16], store_data[15:0]};
      default: merge_word = store_data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end for the 32-word data RAM: latches one CPU request,
// validates it, then performs the load, full store or read-modify-write store.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int RAM_AW = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              mem_wr,
  input  logic [2:0]        mem_op,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [31:0]       ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t      state;
  logic        wr_q;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;

  logic        acc_err;
  logic        sw_ok;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  mem_lane_align u_align (
    .op         (op_q),
    .lane       (addr_q[1:0]),
    .ram_word   (ram_rdata),
    .store_data (wdata_q),
    .load_val   (load_val),
    .merge_word (merge_val)
  );

  // Out-of-range addresses are rejected rather than aliased onto the RAM.
  always_comb begin
    acc_err = !is_legal_op(op_q, wr_q) ||
              (|addr_q[31:RAM_AW+2]) ||
              ((op_q[1:0] == 2'b01) && addr_q[0]) ||
              ((op_q == OP_W) && (addr_q[1:0] != 2'b00));
    sw_ok   = wr_q && (op_q == OP_W) && !acc_err;
  end

  assign ram_addr = {2'b00, addr_q[31:2]};
  assign ram_we   = (state == S_WRITE) || ((state == S_ACCESS) && sw_ok);

  always_comb begin
    ram_wdata = '0;
    if (state == S_WRITE)
      ram_wdata = merge_q;
    else if ((state == S_ACCESS) && sw_ok)
      ram_wdata = wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      wr_q    <= 1'b0;
      op_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      merge_q <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            wr_q    <= mem_wr;
            op_q    <= mem_op;
            addr_q  <= addr;
            wdata_q <= wdata;
            ready   <= 1'b0;
            state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (acc_err) begin
            err   <= 1'b1;
            rdata <= '0;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (!wr_q) begin
            rdata <= load_val;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (op_q == OP_W) begin
            rdata <= '0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            merge_q <= merge_val;
            state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          rdata <= '0;
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          rdata <= '0;
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random
// traffic compared against an arithmetic reference model of the RAM contents.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        mem_wr = 1'b0;
  logic [2:0]  mem_op = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        ready, done, err, ram_we;
  logic [31:0] rdata, ram_addr, ram_wdata, ram_rdata;

  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  logic        mem_init = 1'b1;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_rdata;
  logic [31:0] last_we_data;

  mem_access_unit #(.RAM_AW(5), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mem_wr    (mem_wr),
    .mem_op    (mem_op),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Data RAM: async read, write committed on the falling edge.
  always @(negedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h8000_0000 + 32'(i);
    end else if (ram_we && (ram_addr < 32)) begin
      mem[ram_addr[4:0]] <= ram_wdata;
    end
  end

  assign ram_rdata = (ram_addr < 32) ? mem[ram_addr[4:0]] : 32'h0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: byte-addressed semantics computed with plain arithmetic.
  function automatic void modelOp(input logic wr, input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] wd, output logic e, output logic [31:0] rd,
                                  output int lat, output logic we, output logic [31:0] word);
    int size;
    bit legal;
    int sh;
    logic [31:0] mask, w, v;
    legal = (op == 0 || op == 1 || op == 2 || op == 4 || op == 5) && !(wr && op >= 4);
    size  = (op % 4 == 0) ? 1 : (op % 4 == 1) ? 2 : 4;
    e     = !legal || (a >= 128) || (a % size != 0);
    rd = 32'h0; we = 1'b0; word = 32'h0; lat = 2;
    if (!e) begin
      w    = ref_mem[a / 4];
      sh   = 8 * int'(a % 4);
      mask = (size == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * size)) - 1);
      if (!wr) begin
        v = (w >> sh) & mask;
        if (op < 4 && size < 4 && v[8 * size - 1]) v = v | ~mask;
        rd = v;
      end else begin
        we   = 1'b1;
        word = (w & ~(mask << sh)) | ((wd & mask) << sh);
        lat  = (size == 4) ? 2 : 3;
      end
    end
  endfunction

  task automatic applyStimulus(input logic wr, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] wd, input string tag);
    logic e_exp, we_exp, we_seen, got_err;
    logic [31:0] rd_exp, word_exp, we_data, got_rd;
    int lat_exp, lat;
    modelOp(wr, op, a, wd, e_exp, rd_exp, lat_exp, we_exp, word_exp);
    checkOutput({tag, ".ready"}, 32'(ready), 32'd1);
    mem_wr = wr; mem_op = op; addr = a; wdata = wd; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 0; we_seen = 1'b0; we_data = 32'h0; got_err = 1'b0; got_rd = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      if (ram_we) begin we_seen = 1'b1; we_data = ram_wdata; end
      if (done) begin lat = k; got_err = err; got_rd = rdata; break; end
      @(posedge clk); #1;
    end
    checkOutput({tag, ".latency"}, 32'(lat), 32'(lat_exp));
    checkOutput({tag, ".err"}, 32'(got_err), 32'(e_exp));
    checkOutput({tag, ".rdata"}, got_rd, rd_exp);
    checkOutput({tag, ".ram_we"}, 32'(we_seen), 32'(we_exp));
    if (we_exp) begin
      checkOutput({tag, ".ram_wdata"}, we_data, word_exp);
      ref_mem[a / 4] = word_exp;
    end
    last_rdata = got_rd;
    last_we_data = we_data;
    @(posedge clk); #1;
  endtask

  initial begin
    int dones;
    logic [2:0] ops [8];
    logic [2:0] op;
    logic [31:0] a;
    ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h8000_0000 + 32'(i);

    @(negedge clk); #1;
    mem_init = 1'b0;
    checkOutput("reset.ready", 32'(ready), 32'd1);
    checkOutput("reset.done", 32'(done), 32'd0);
    checkOutput("reset.err", 32'(err), 32'd0);
    checkOutput("reset.rdata", rdata, 32'h0);
    checkOutput("reset.ram_we", 32'(ram_we), 32'd0);
    checkOutput("reset.ram_addr", ram_addr, 32'h0);
    checkOutput("reset.ram_wdata", ram_wdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(1'b0, 3'b010, 32'h0C, 32'h0, "lw_0c");
    checkOutput("lw_0c.literal", last_rdata, 32'h8000_0003);
    applyStimulus(1'b0, 3'b000, 32'h0F, 32'h0, "lb_0f");
    checkOutput("lb_0f.literal", last_rdata, 32'hFFFF_FF80);
    applyStimulus(1'b0, 3'b100, 32'h0F, 32'h0, "lbu_0f");
    checkOutput("lbu_0f.literal", last_rdata, 32'h0000_0080);
    applyStimulus(1'b0, 3'b101, 32'h0E, 32'h0, "lhu_0e");
    checkOutput("lhu_0e.literal", last_rdata, 32'h0000_8000);
    applyStimulus(1'b1, 3'b000, 32'h09, 32'h1234_56AB, "sb_09");
    checkOutput("sb_09.literal", last_we_data, 32'h8000_AB02);
    applyStimulus(1'b0, 3'b010, 32'h08, 32'h0, "lw_08");
    checkOutput("lw_08.literal", last_rdata, 32'h8000_AB02);
    applyStimulus(1'b1, 3'b001, 32'h05, 32'h5555_AAAA, "sh_05");
    checkOutput("sh_05.word1", mem[1], 32'h8000_0001);
    applyStimulus(1'b0, 3'b010, 32'h80, 32'h0, "lw_80");
    applyStimulus(1'b0, 3'b011, 32'h04, 32'h0, "op_011");

    // Reset pulse inside the ACCESS cycle of a store, before the RAM's falling edge.
    mem_wr = 1'b1; mem_op = 3'b010; addr = 32'h10; wdata = 32'hDEAD_BEEF; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid.ram_we", 32'(ram_we), 32'd0);
    #1;
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    checkOutput("rst_mid.no_done", 32'(dones), 32'd0);
    checkOutput("rst_mid.ready", 32'(ready), 32'd1);
    checkOutput("rst_mid.word4", mem[4], 32'h8000_0004);

    // req held high: one accept per IDLE visit.
    checkOutput("b2b.ready0", 32'(ready), 32'd1);
    mem_wr = 1'b0; mem_op = 3'b010; addr = 32'h0C; req = 1'b1;
    dones = 0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 9) req = 1'b0;
      checkOutput($sformatf("b2b.ready%0d", k), 32'(ready), 32'(k % 3 == 0));
      if (done) begin
        dones++;
        checkOutput($sformatf("b2b.rdata%0d", k), rdata, 32'h8000_0003);
      end
    end
    checkOutput("b2b.dones", 32'(dones), 32'd3);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) begin
        if (op[1:0] == 2'b01) a[0] = 1'b0;
        if (op[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      applyStimulus(1'($urandom_range(0, 1)), op, a, $urandom, $sformatf("rand%0d", i));
    end

    for (int i = 0; i < 32; i++)
      checkOutput($sformatf("final.mem%0d", i), mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
